// File: rtl/gf180mcu_fd_sc_mcu9t5v0__clkmon_pkg.sv
// Shared types and helpers for the buffered-clock-net monitor.
package gf180mcu_fd_sc_mcu9t5v0__clkmon_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    RUN  = 2'd2
  } state_t;

  // Increment by one when inc is set, never past max_val.
  function automatic logic [31:0] sat_inc(input logic [31:0] val,
                                          input logic        inc,
                                          input logic [31:0] max_val);
    if (inc && (val < max_val)) return val + 32'd1;
    return val;
  endfunction

endpackage

// File: rtl/gf180mcu_fd_sc_mcu9t5v0__clkmon_sync.sv
// Synchroniser for the monitored net plus a registered rising-edge detector.
module gf180mcu_fd_sc_mcu9t5v0__clkmon_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic CLK,
  input  logic RN,
  input  logic I,
  output logic e
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s_prev;
  logic                   s_sync;

  assign s_sync = sync_q[SYNC_STAGES-1];

  // Runs regardless of EN so the chain is already settled when a window starts.
  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      sync_q <= '0;
      s_prev <= 1'b0;
      e      <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], I};
      s_prev <= s_sync;
      e      <= s_sync & ~s_prev;
    end
  end

endmodule

// File: rtl/gf180mcu_fd_sc_mcu9t5v0__clkmon.sv
// Clock-net monitor: counts rising edges of I per WINDOW cycles of CLK and flags slow/fast.
// state | meaning
// IDLE  | stopped, counters held at zero
// ARM   | one cycle letting the edge detector prime, nothing counted
// RUN   | counting; window end publishes CNT/LO/HI and pulses VLD
module gf180mcu_fd_sc_mcu9t5v0__clkmon
  import gf180mcu_fd_sc_mcu9t5v0__clkmon_pkg::*;
#(
  parameter int WINDOW      = 64,
  parameter int WIN_W       = 8,
  parameter int CNT_W       = 6,
  parameter int MIN_EDGES   = 4,
  parameter int MAX_EDGES   = 24,
  parameter int SYNC_STAGES = 2
) (
  input  logic             CLK,
  input  logic             RN,
  input  logic             EN,
  input  logic             I,
  output logic [CNT_W-1:0] CNT,
  output logic             VLD,
  output logic             LO,
  output logic             HI,
  output logic             BUSY
);

  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW - 1);
  localparam logic [31:0]      CNT_MAX  = 32'((64'd1 << CNT_W) - 64'd1);
  localparam logic [31:0]      MIN_L    = 32'(MIN_EDGES);
  localparam logic [31:0]      MAX_L    = 32'(MAX_EDGES);

  state_t           state, state_n;
  logic [WIN_W-1:0] win, win_n;
  logic [CNT_W-1:0] edge_cnt, edge_cnt_n;
  logic [CNT_W-1:0] cnt_n, total;
  logic             vld_n, lo_n, hi_n;
  logic             e;

  gf180mcu_fd_sc_mcu9t5v0__clkmon_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .CLK (CLK),
    .RN  (RN),
    .I   (I),
    .e   (e)
  );

  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      state    <= IDLE;
      win      <= '0;
      edge_cnt <= '0;
      CNT      <= '0;
      VLD      <= 1'b0;
      LO       <= 1'b0;
      HI       <= 1'b0;
    end else begin
      state    <= state_n;
      win      <= win_n;
      edge_cnt <= edge_cnt_n;
      CNT      <= cnt_n;
      VLD      <= vld_n;
      LO       <= lo_n;
      HI       <= hi_n;
    end
  end

  always_comb begin
    state_n    = state;
    win_n      = win;
    edge_cnt_n = edge_cnt;
    cnt_n      = CNT;
    lo_n       = LO;
    hi_n       = HI;
    vld_n      = 1'b0;
    total      = CNT_W'(sat_inc(32'(edge_cnt), e, CNT_MAX));
    unique case (state)
      IDLE: begin
        win_n      = '0;
        edge_cnt_n = '0;
        if (EN) state_n = ARM;
      end
      ARM: begin
        win_n      = '0;
        edge_cnt_n = '0;
        state_n    = EN ? RUN : IDLE;
      end
      RUN: begin
        // Dropping EN always wins, even on the window-end cycle.
        if (!EN) begin
          state_n    = IDLE;
          win_n      = '0;
          edge_cnt_n = '0;
        end else if (win == WIN_LAST) begin
          win_n      = '0;
          edge_cnt_n = '0;
          cnt_n      = total;
          lo_n       = (32'(total) < MIN_L);
          hi_n       = (32'(total) > MAX_L);
          vld_n      = 1'b1;
        end else begin
          win_n      = win + WIN_W'(1);
          edge_cnt_n = total;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign BUSY = (state != IDLE);

endmodule
